// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared RV32M constants and sequencer state encoding
package muldiv_seq_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] MULf3    = 3'b000;
  localparam logic [2:0] MULHf3   = 3'b001;
  localparam logic [2:0] MULHSUf3 = 3'b010;
  localparam logic [2:0] MULHUf3  = 3'b011;
  localparam logic [2:0] DIVf3    = 3'b100;
  localparam logic [2:0] DIVUf3   = 3'b101;
  localparam logic [2:0] REMf3    = 3'b110;
  localparam logic [2:0] REMUf3   = 3'b111;

  localparam logic [6:0] MEXT_F7 = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/muldiv_dp.sv
// rtl/muldiv_dp.sv - magnitude shift-add multiplier / restoring divider datapath
// Loads on i_load, iterates on i_step, applies sign fix and result select on i_fix.
module muldiv_dp
  import muldiv_seq_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_fix,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_fast,
  output logic [XLEN-1:0] o_result
);

  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_neg;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_result;

  logic              w_a_signed, w_b_signed, w_neg_a, w_neg_b, w_neg_res;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div0, w_ovf;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN:0]     w_add;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_fix_res;

  // Operands enter the loop as magnitudes; r_neg records whether the final word must be negated.
  assign w_a_signed = (i_func3 == MULHf3) | (i_func3 == MULHSUf3) | (i_func3 == DIVf3) | (i_func3 == REMf3);
  assign w_b_signed = (i_func3 == MULHf3) | (i_func3 == DIVf3) | (i_func3 == REMf3);
  assign w_neg_a    = w_a_signed & i_op_a[XLEN-1];
  assign w_neg_b    = w_b_signed & i_op_b[XLEN-1];
  assign w_a_mag    = w_neg_a ? -i_op_a : i_op_a;
  assign w_b_mag    = w_neg_b ? -i_op_b : i_op_b;
  assign w_neg_res  = (i_func3 == REMf3) ? w_neg_a : (w_neg_a ^ w_neg_b);

  assign w_div0     = i_func3[2] & (i_op_b == '0);
  assign w_ovf      = i_func3[2] & ~i_func3[0] & (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_op_b == '1);
  assign o_fast     = w_div0 | w_ovf;
  assign w_fast_res = i_func3[1] ? (w_div0 ? i_op_a : '0) : (w_div0 ? '1 : i_op_a);

  assign w_add   = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_a};
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[XLEN-1:0] - r_b;

  assign w_prod_fix = r_neg ? -r_prod : r_prod;
  assign w_quo_fix  = r_neg ? -r_quo : r_quo;
  assign w_rem_fix  = r_neg ? -r_rem : r_rem;

  always_comb begin
    w_fix_res = '0;
    case (r_f3)
      MULf3:                     w_fix_res = w_prod_fix[XLEN-1:0];
      MULHf3, MULHSUf3, MULHUf3: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      DIVf3, DIVUf3:             w_fix_res = w_quo_fix;
      default:                   w_fix_res = w_rem_fix;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_f3     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_prod   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else if (i_load) begin
      r_f3   <= i_func3;
      r_a    <= w_a_mag;
      r_b    <= w_b_mag;
      r_neg  <= w_neg_res;
      r_prod <= {{XLEN{1'b0}}, w_b_mag};
      r_quo  <= w_a_mag;
      r_rem  <= '0;
      if (o_fast) r_result <= w_fast_res;
    end else if (i_step) begin
      if (r_f3[2]) begin
        r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], w_ge};
      end else begin
        r_prod <= r_prod[0] ? {w_add, r_prod[XLEN-1:1]} : {1'b0, r_prod[2*XLEN-1:1]};
      end
    end else if (i_fix) begin
      r_result <= w_fix_res;
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - RV32M iterative multiply/divide sequencer (FSM, counter, handshake)
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_stall
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_load, w_step, w_fix, w_fast;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_fix        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_load = 1'b1;
          if (w_fast) begin
            w_state_next = S_DONE;
          end else begin
            w_cnt_next   = CNT_W'(XLEN - 1);
            w_state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == '0) w_state_next = S_FIX;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      S_FIX: begin
        w_fix        = 1'b1;
        w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  muldiv_dp u_dp (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_fix    (w_fix),
    .i_func3  (i_func3),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .o_fast   (w_fast),
    .o_result (o_result)
  );

  assign o_busy  = (r_state == S_RUN) | (r_state == S_FIX);
  assign o_done  = (r_state == S_DONE);
  // The core advances on the edge that ends the done cycle.
  assign o_stall = i_start & ~o_done;

endmodule
